// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritised write
// ports, optional write-to-read bypass, hardwired r0, and a sequential clear engine.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cidx;
  logic [DATA_W-1:0]   regs [DEPTH];

  logic wr_acc;
  logic wr0;
  logic wr1;

  // Writes land only in READY and only when no clear is being requested this edge.
  assign wr_acc = (state == S_READY) && !clr;
  assign wr1    = wr_acc && we1 && (waddr1 != '0);
  assign wr0    = wr_acc && we0 && (waddr0 != '0) && !(wr1 && (waddr1 == waddr0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_INIT;
      cidx  <= FIRST_IDX;
      busy  <= 1'b1;
    end else if (clr) begin
      state <= S_INIT;
      cidx  <= FIRST_IDX;
      busy  <= 1'b1;
    end else if (state == S_INIT) begin
      if (cidx == LAST_IDX) begin
        state <= S_READY;
        busy  <= 1'b0;
        cidx  <= FIRST_IDX;
      end else begin
        cidx <= cidx + FIRST_IDX;
      end
    end
  end

  // Storage has no reset: the clear engine zeroes it after every reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == S_INIT) begin
        regs[cidx] <= '0;
      end else begin
        if (wr0) regs[waddr0] <= wdata0;
        if (wr1) regs[waddr1] <= wdata1;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd = '0;
      if (rst && (state == S_READY) && (ra != '0) && re[i]) begin
        if ((BYPASS != 0) && wr1 && (waddr1 == ra)) begin
          rd = wdata1;
        end else if ((BYPASS != 0) && wr0 && (waddr0 == ra)) begin
          rd = wdata0;
        end else begin
          rd = regs[ra];
        end
      end
    end

    assign rdata[i*DATA_W +: DATA_W] = rd;
  end

endmodule
